// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and types for generic pipeline stage registers
//
// Purpose: common widths and control-bit positions so every stage packs in_ctrl
//          the same way, plus the stage-state encoding used by pipe_stage_skid_reg.
package pipe_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_CTRL_W = 8;

    // Control-bit positions inside in_ctrl / out_ctrl.
    localparam int CTRL_WB_EN  = 0;
    localparam int CTRL_MEM_R  = 1;
    localparam int CTRL_MEM_W  = 2;
    localparam int CTRL_B      = 3;
    localparam int CTRL_S      = 4;

    // Stage state is {s_valid, m_valid}; a held skid entry without a main entry
    // cannot occur because the skid only fills behind an occupied main entry.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_ONE     = 2'b01,
        ST_ILLEGAL = 2'b10,
        ST_FULL    = 2'b11
    } stage_state_e;

    function automatic logic [1:0] occ_count(input logic m_valid, input logic s_valid);
        return {1'b0, m_valid} + {1'b0, s_valid};
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one valid+ctrl+data holding register of a pipeline stage
//
// Purpose: single buffer entry with load, invalidate and clear (squash) controls.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             squash: valid and ctrl to 0, data to 0 only when CLR_DATA != 0
//   load              capture d_data/d_ctrl and mark the entry valid
//   invalidate        mark the entry empty, payload kept
//   d_data, d_ctrl    payload and control to capture
//   q_valid, q_data, q_ctrl  registered entry contents
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W   = PIPE_DATA_W,
    parameter int CTRL_W   = PIPE_CTRL_W,
    parameter int CLR_DATA = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              invalidate,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

    // clear outranks load so a squash can never be overridden by a capture.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clear) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (CLR_DATA != 0) begin
                data_d = '0;
            end
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d_data;
            ctrl_d  = d_ctrl;
        end else if (invalidate) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign q_valid = valid_q;
    assign q_data  = data_q;
    assign q_ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - parametrised pipeline stage register with main/skid buffer
//
// Purpose: moves payload + control between pipeline stages with valid/ready,
//          freeze (stall) and flush (squash). A second (skid) entry absorbs the
//          beat in flight when out_ready drops, so in_ready is a function of
//          registered state and freeze/flush only, never of out_ready.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   freeze, flush       stall / synchronous squash (flush has priority)
//   in_valid, in_ready, in_data, in_ctrl      upstream handshake and beat
//   out_valid, out_ready, out_data, out_ctrl  downstream handshake and main entry
//   occupancy           number of held entries (0..2)
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W         = PIPE_DATA_W,
    parameter int CTRL_W         = PIPE_CTRL_W,
    parameter int FLUSH_CLR_DATA = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              m_valid, s_valid;
    logic [DATA_W-1:0] m_data,  s_data;
    logic [CTRL_W-1:0] m_ctrl,  s_ctrl;

    logic              accept, release_beat;
    logic              m_load, m_from_skid, m_inval;
    logic              s_load, s_inval;
    logic [DATA_W-1:0] m_d_data;
    logic [CTRL_W-1:0] m_d_ctrl;
    stage_state_e      state;

    // Freeze and flush mask both handshakes, so every register holds under
    // freeze and no beat crosses either boundary in a flush cycle.
    assign in_ready     = ~s_valid & ~freeze & ~flush;
    assign out_valid    = m_valid & ~freeze & ~flush;
    assign out_data     = m_data;
    assign out_ctrl     = m_valid ? m_ctrl : '0;
    assign occupancy    = occ_count(m_valid, s_valid);

    assign accept       = in_valid & in_ready;
    assign release_beat = out_valid & out_ready;

    assign state        = stage_state_e'({s_valid, m_valid});

    always_comb begin
        m_load      = 1'b0;
        m_from_skid = 1'b0;
        m_inval     = 1'b0;
        s_load      = 1'b0;
        s_inval     = 1'b0;
        case (state)
            ST_EMPTY: begin
                m_load = accept;
            end
            ST_ONE: begin
                if (accept && release_beat) begin
                    m_load = 1'b1;
                end else if (accept) begin
                    s_load = 1'b1;
                end else if (release_beat) begin
                    m_inval = 1'b1;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the skid-to-main move is possible.
                if (release_beat) begin
                    m_load      = 1'b1;
                    m_from_skid = 1'b1;
                    s_inval     = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign m_d_data = m_from_skid ? s_data : in_data;
    assign m_d_ctrl = m_from_skid ? s_ctrl : in_ctrl;

    pipe_entry_reg #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CLR_DATA (FLUSH_CLR_DATA)
    ) u_main (
        .clk        (clk),
        .rst_n      (rst),
        .clear      (flush),
        .load       (m_load),
        .invalidate (m_inval),
        .d_data     (m_d_data),
        .d_ctrl     (m_d_ctrl),
        .q_valid    (m_valid),
        .q_data     (m_data),
        .q_ctrl     (m_ctrl)
    );

    pipe_entry_reg #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CLR_DATA (FLUSH_CLR_DATA)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst),
        .clear      (flush),
        .load       (s_load),
        .invalidate (s_inval),
        .d_data     (in_data),
        .d_ctrl     (in_ctrl),
        .q_valid    (s_valid),
        .q_data     (s_data),
        .q_ctrl     (s_ctrl)
    );

    a_no_skid_without_main: assert property (
        @(posedge clk) disable iff (!rst) !(s_valid && !m_valid)
    );

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Generic, parametrised pipeline stage register; the successor to the fixed per-stage IF/ID/EX/MEM registers.
- Carries a data payload plus a control bundle (WB_EN, MEM_R_EN, MEM_W_EN, B, S, ...) between stages with a valid/ready handshake, stage freeze (hazard stall) and flush (branch squash).
- A 2-entry main/skid buffer keeps full throughput while in_ready depends only on registered state and the global freeze/flush inputs, never on out_ready.

Parameters:
DATA_W, 32, payload width (PC, operands, immediates packed by the instantiating stage)
CTRL_W, 8, control-bit width; control bits are forced to 0 on flush and on bubbles
FLUSH_CLR_DATA, 0, 1 = payload registers also cleared to 0 on flush; 0 = payload held

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-low
freeze  input  1  stall; no transfer on either side while high
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream beat present
in_ready  output  1  stage can accept
in_data  input  DATA_W  upstream payload
in_ctrl  input  CTRL_W  upstream control bits
out_valid  output  1  beat available downstream
out_ready  input  1  downstream accepts
out_data  output  DATA_W  payload of main entry
out_ctrl  output  CTRL_W  control of main entry; 0 when main entry invalid
occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Storage: main entry M (m_valid, m_data, m_ctrl) and skid entry S (s_valid, s_data, s_ctrl).
- Reset (rst=0, asynchronous): all valids, data, ctrl and occupancy are 0. in_ready = 1 and out_valid = 0 once freeze and flush are low.
- Combinational outputs:
  - in_ready = ~s_valid & ~freeze & ~flush
  - out_valid = m_valid & ~freeze & ~flush
  - out_data = m_data
  - out_ctrl = m_valid ? m_ctrl : 0
- Transfers: accept = in_valid & in_ready; release = out_valid & out_ready.
- States (derived from {s_valid, m_valid}): EMPTY=00, ONE=01, FULL=11. The combination 10 is illegal and must never occur (assertion).
- EMPTY: accept -> ONE, M <= in.
- ONE:
  - accept & release -> ONE, M <= in.
  - accept & ~release -> FULL, S <= in.
  - ~accept & release -> EMPTY.
  - Neither -> hold.
- FULL: in_ready = 0. release -> ONE, M <= S, S cleared to invalid. No release -> hold.
- Latency: 1 cycle from accept to out_valid when EMPTY. Sustained throughput of 1 beat/cycle with out_ready held high.
- Back-pressure: out_ready dropping with a beat in flight costs no data; the beat lands in S. in_ready falls the cycle after S fills.
- freeze: every register holds its value; in/out handshakes are masked so nothing is lost or duplicated.
- flush: highest priority, above freeze and all handshakes.
  - Next state EMPTY; m_ctrl and s_ctrl cleared to 0.
  - Payload is cleared only if FLUSH_CLR_DATA=1.
  - No transfer occurs in the flush cycle: an upstream beat presented that cycle is dropped, and the downstream sees no valid beat.
- Reset mid-stream: immediately empties the stage; no partial beat is emitted after release.
- occupancy = m_valid + s_valid, registered-derived, no glitches from inputs.

Decomposition:
- Shared package (pipe_pkg): constants PIPE_DATA_W=32, PIPE_CTRL_W=8, and control-bit index localparams CTRL_WB_EN=0, CTRL_MEM_R=1, CTRL_MEM_W=2, CTRL_B=3, CTRL_S=4, so all stages pack in_ctrl identically.
- Sub-module: pipe_entry_reg. One valid+ctrl+data register with load, clear-ctrl and optional clear-data controls, instantiated twice (M and S). FSM and handshake logic stay in the top module.

Test Plan:
- Reset, then stream beats in_data=0x10..0x17 with out_ready=1 -> outputs appear 1 cycle later in order, one per cycle, occupancy stays 1, in_ready stays 1.
- Send 0xA1, 0xA2, 0xA3 with out_ready=0 -> occupancy 1 then 2, in_ready falls after 0xA2, 0xA3 is not accepted. Raise out_ready -> 0xA1 and 0xA2 delivered, then 0xA3 accepted; no loss or duplication.
- FULL state, freeze=1 for 3 cycles with in_valid=1 and out_ready=1 -> no transfers, outputs stable. Freeze=0 -> drains in order.
- FULL with in_ctrl=0x1F; pulse flush while in_valid=1 -> next cycle occupancy=0 and out_ctrl=0. Out_data is held with FLUSH_CLR_DATA=0 and is 0 with FLUSH_CLR_DATA=1. The flushed-cycle input never appears.
- flush and freeze asserted together in ONE -> stage empties (flush wins).
- Assert rst=0 asynchronously mid-cycle in FULL -> outputs go to 0 immediately without a clock edge. After release the stage accepts a new beat 0x55 and emits it 1 cycle later.
